// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus drain sequencer feeding a UART transmitter over its valid/data/busy handshake.
// The optional UART_TX_FIFO_DROP_COUNT_EN macro adds a saturating drop counter, drop_count_o.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             wr_valid_i,
  input  logic [7:0]       wr_data_i,
  output logic             wr_ready_o,
  input  logic             flush_i,
  input  logic             uart_busy_i,
  output logic             uart_data_valid_o,
  output logic [7:0]       uart_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
`ifdef UART_TX_FIFO_DROP_COUNT_EN
  ,
  output logic [15:0]      drop_count_o
`endif
);

  localparam int ADDR_W = CNT_W - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_wr, do_pop, do_drop;

  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign wr_ready_o = !full_o;

  // Full is judged on the pre-edge count, so a same-cycle pop does not rescue a write.
  assign do_drop = wr_valid_i && full_o;
  assign do_wr   = wr_valid_i && !full_o && !flush_i;

  always_comb begin
    state_d = state_q;
    do_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_o && !uart_busy_i && !flush_i) begin
          do_pop  = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (uart_busy_i) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!uart_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q           <= IDLE;
      uart_data_valid_o <= 1'b0;
      uart_data_o       <= 8'h00;
    end else begin
      state_q           <= state_d;
      uart_data_valid_o <= do_pop;
      if (do_pop) uart_data_o <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= do_drop;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_wr)  wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (do_pop) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_pop);
      end
    end
  end

  // Storage needs no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data_i;
  end

`ifdef UART_TX_FIFO_DROP_COUNT_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      drop_count_o <= 16'h0000;
    end else if (flush_i) begin
      drop_count_o <= 16'h0000;
    end else if (do_drop && (drop_count_o != 16'hFFFF)) begin
      drop_count_o <= drop_count_o + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo (DEPTH=4) against a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr;
  logic [7:0]       wdat;
  logic             flush;
  logic             busy;
  logic             ready, vld, empty, full, ovf;
  logic [7:0]       udat;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      dcnt;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_ni(rst_n), .wr_valid_i(wr), .wr_data_i(wdat),
    .wr_ready_o(ready), .flush_i(flush), .uart_busy_i(busy),
    .uart_data_valid_o(vld), .uart_data_o(udat), .count_o(cnt),
    .empty_o(empty), .full_o(full), .overflow_o(ovf)
`ifdef UART_TX_FIFO_DROP_COUNT_EN
    , .drop_count_o(dcnt)
`endif
  );
`ifndef UART_TX_FIFO_DROP_COUNT_EN
  assign dcnt = 16'h0000;
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus "sequencer free / busy seen" flags.
  logic [7:0] q[$];
  bit         m_free, m_seen;
  bit         e_vld, e_ovf;
  logic [7:0] e_dat;
  int         e_dcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_free = 1; m_seen = 0;
      e_vld = 0; e_ovf = 0; e_dat = 8'h00; e_dcnt = 0;
    end else begin
      int  n;
      bit  f, pop;
      n   = q.size();
      f   = (n == DEPTH);
      pop = m_free && n > 0 && !busy && !flush;
      e_ovf = wr && f;
      if (flush) e_dcnt = 0;
      else if (e_ovf && e_dcnt < 65535) e_dcnt++;
      e_vld = pop;
      if (flush) q.delete();
      else begin
        if (pop) e_dat = q.pop_front();
        if (wr && !f) q.push_back(wdat);
      end
      if (pop) begin m_free = 0; m_seen = 0; end
      else if (!m_free && !m_seen && busy) m_seen = 1;
      else if (!m_free && m_seen && !busy) m_free = 1;
    end
  end

  // Transmitter model: busy rises the cycle after a request and stays high hold_len cycles.
  bit force_busy = 0;
  int hold_len   = 3;
  int hold       = 0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin busy = 0; hold = 0; end
    else if (force_busy) busy = 1;
    else if (vld) begin
      busy = 1;
      hold = (hold_len == 0) ? int'($urandom_range(1, 5)) : hold_len;
    end
    else if (hold > 1) hold--;
    else begin hold = 0; busy = 0; end
  end

  // Compare process plus request/overflow recorder.
  logic [7:0] log_q[$];
  int         ovf_seen = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", int'(vld), int'(e_vld));
      chk("data", int'(udat), int'(e_dat));
      chk("count", int'(cnt), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("wr_ready", int'(ready), int'(q.size() != DEPTH));
      chk("overflow", int'(ovf), int'(e_ovf));
`ifdef UART_TX_FIFO_DROP_COUNT_EN
      chk("drop_count", int'(dcnt), e_dcnt);
`endif
      if (vld) chk("valid_during_busy", int'(busy), 0);
      if (vld) log_q.push_back(udat);
      if (ovf) ovf_seen++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    wr = 1; wdat = b;
    step();
    wr = 0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin step(); c++; end
    if (log_q.size() < n) chk("log_timeout", log_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((busy || q.size() != 0 || !m_free) && c < budget) begin step(); c++; end
    repeat (3) step();
  endtask

  initial begin
    rst_n = 0; wr = 0; wdat = 8'h00; flush = 0;
    repeat (2) step();
    chk("rst_count", int'(cnt), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_ready", int'(ready), 1);
    chk("rst_valid", int'(vld), 0);
    rst_n = 1;
    step();

    // Single byte: request appears one edge after the write edge.
    log_q.delete();
    put(8'h61);
    chk("lat_valid_early", int'(vld), 0);
    step();
    chk("lat_valid", int'(vld), 1);
    chk("lat_data", int'(udat), 8'h61);
    step();
    chk("lat_valid_one_cycle", int'(vld), 0);
    wait_idle(100);
    chk("single_count", int'(cnt), 0);
    chk("single_log", log_q.size(), 1);

    // Burst with long busy.
    hold_len = 100;
    log_q.delete();
    for (int i = 1; i <= 5; i++) put(8'(i));
    wait_log(5, 800);
    for (int i = 0; i < 5; i++)
      chk("burst_order", (i < log_q.size()) ? int'(log_q[i]) : -1, i + 1);
    wait_idle(300);

    // Full / overflow with busy held.
    hold_len = 3;
    force_busy = 1;
    step();
    ovf_seen = 0;
    log_q.delete();
    for (int i = 0; i < 6; i++) put(8'hB0 + 8'(i));
    step();
    chk("full_flag", int'(full), 1);
    chk("full_ready", int'(ready), 0);
    chk("full_count", int'(cnt), 4);
    chk("ovf_pulses", ovf_seen, 2);
`ifdef UART_TX_FIFO_DROP_COUNT_EN
    chk("drop_count_lit", int'(dcnt), 2);
`endif
    force_busy = 0;
    wait_log(4, 200);
    for (int i = 0; i < 4; i++)
      chk("full_order", (i < log_q.size()) ? int'(log_q[i]) : -1, 8'hB0 + i);
    wait_idle(100);

    // Simultaneous write and pop at count 1.
    log_q.delete();
    wr = 1; wdat = 8'hC1;
    step();
    wdat = 8'hC2;
    step();
    wr = 0;
    chk("simul_count", int'(cnt), 1);
    wait_log(2, 100);
    chk("simul_first", (log_q.size() > 0) ? int'(log_q[0]) : -1, 8'hC1);
    chk("simul_second", (log_q.size() > 1) ? int'(log_q[1]) : -1, 8'hC2);
    wait_idle(100);

    // Flush while the first byte is in flight.
    hold_len = 20;
    log_q.delete();
    for (int i = 0; i < 3; i++) put(8'hD0 + 8'(i));
    flush = 1;
    step();
    flush = 0;
    chk("flush_count", int'(cnt), 0);
    chk("flush_empty", int'(empty), 1);
    repeat (50) step();
    chk("flush_log_size", log_q.size(), 1);
    chk("flush_log_byte", (log_q.size() > 0) ? int'(log_q[0]) : -1, 8'hD0);

    // Async reset during WAIT_DONE, then normal operation.
    hold_len = 30;
    put(8'h3C);
    put(8'h3D);
    repeat (6) step();
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", int'(vld), 0);
    chk("arst_data", int'(udat), 0);
    chk("arst_count", int'(cnt), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_ready", int'(ready), 1);
    chk("arst_ovf", int'(ovf), 0);
    repeat (2) step();
    rst_n = 1;
    step();
    hold_len = 3;
    log_q.delete();
    put(8'hA5);
    wait_log(1, 50);
    chk("arst_a5", (log_q.size() > 0) ? int'(log_q[0]) : -1, 8'hA5);
    wait_idle(100);

    // Randomised traffic with random busy lengths.
    hold_len = 0;
    for (int c = 0; c < 4000; c++) begin
      wr    = ($urandom_range(0, 99) < 45);
      wdat  = 8'($urandom);
      flush = ($urandom_range(0, 59) == 0);
      step();
    end
    wr = 0; flush = 0;
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and drain sequencer directly upstream of the UART transmitter in the camera_test design.
- Accepts bursts of bytes from producers (camera pixel packer, debug traffic) at system clock rate.
- Stores them in a circular FIFO and hands them one at a time to the transmitter via its data_valid/data/busy handshake, so producers never have to watch transmitter busy themselves.

Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden).

Ports:
- clk_i  input  1  system clock; all logic on posedge.
- reset_ni  input  1  asynchronous, active-low reset.
- wr_valid_i  input  1  producer write strobe.
- wr_data_i  input  8  producer byte.
- wr_ready_o  output  1  high when the FIFO is not full; equals !full_o.
- flush_i  input  1  synchronous discard of all stored bytes.
- uart_busy_i  input  1  busy flag from the transmitter.
- uart_data_valid_o  output  1  one-cycle request to the transmitter.
- uart_data_o  output  8  byte to the transmitter; held stable between requests.
- count_o  output  CNT_W  current occupancy, 0..DEPTH.
- empty_o  output  1  count_o == 0.
- full_o  output  1  count_o == DEPTH.
- overflow_o  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (async assert, sync release by design): rd/wr pointers 0, count_o 0, empty_o 1, full_o 0, wr_ready_o 1, overflow_o 0, uart_data_valid_o 0, uart_data_o 8'h00, FSM IDLE. Reset mid-transfer abandons the in-flight byte; the transmitter is reset by the same source.
- Write: wr_valid_i && !full_o at an edge stores wr_data_i at wr_ptr, wr_ptr+1 mod DEPTH, count+1.
- Drop: wr_valid_i && full_o drops the byte and pulses overflow_o high for the next cycle. This holds even if a pop occurs the same cycle, because full is judged on the pre-edge count.
- Pointers are ADDR_W = CNT_W-1 bits and wrap naturally. count_o is the only full/empty source.
- Drain FSM, all outputs registered:
  - IDLE: if !empty_o && !uart_busy_i, pop the head (rd_ptr+1, count-1), load uart_data_o with the head byte, set uart_data_valid_o=1, go to WAIT_BUSY.
  - WAIT_BUSY: uart_data_valid_o=0. Wait for uart_busy_i=1, then go to WAIT_DONE. The transmitter raises busy one cycle after the request, so this state normally lasts 1 cycle.
  - WAIT_DONE: wait for uart_busy_i=0, then go to IDLE.
- uart_data_valid_o is never high for more than one cycle and never asserted while uart_busy_i is high.
- Latency: a byte written into an empty FIFO at edge k (with the transmitter idle) appears with uart_data_valid_o=1 after edge k+1.
- Gap: the next request follows the busy fall by at least 1 cycle.
- Simultaneous write and pop in the same cycle: count unchanged, both pointers advance. This also applies at count 1: the popped byte is the old head, and the new byte stays stored.
- flush_i: pointers and count go to 0 at the edge. An accompanying write that cycle is ignored, and no pop occurs that cycle. The FSM and any in-flight byte are unaffected, so a byte already requested still transmits.
- uart_data_o holds its last value after a pop and is not cleared by flush.

Optional Feature:
- Macro UART_TX_FIFO_DROP_COUNT_EN.
- When defined: adds output port drop_count_o (16 bits).
  - Increments by 1 on every dropped write and saturates at 16'hFFFF.
  - Cleared by reset_ni and by flush_i. On a flush coinciding with a drop, the flush wins and the result is 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single byte: reset, write 8'h61 with busy low → one-cycle uart_data_valid_o with uart_data_o=8'h61 one edge later; count_o returns to 0.
- Burst with transmitter model (busy 1 cycle after valid, held 100 cycles): write 8'h01..8'h05 back-to-back → five requests in order 01..05, each only after busy falls, never during busy.
- Full/overflow at DEPTH=4: busy held high, write 6 bytes → full_o=1, wr_ready_o=0, two overflow_o pulses, count_o=4; drop_count_o=2 when the macro is on.
- Simultaneous write and pop at count 1 → count stays 1 and the byte order is preserved on the next request.
- Flush: 3 bytes queued, first in flight → flush_i leaves count_o 0 and empty_o 1; the in-flight byte completes and no further requests follow.
- Async reset mid-WAIT_DONE: drop reset_ni between clock edges → outputs reach reset values immediately; after release, a new write 8'hA5 drains normally.
